sm2201_isa_cycle_decoder: RTL and testbench

SM2201_ISA_CYCLE_DECODER -- requirements
Module: sm2201_isa_cycle_decoder

---
 rtl/sm2201_isa_cycle_decoder.sv | 175 +++++++++++++++++
 tb/tb_sm2201_isa_cycle_decoder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sm2201_isa_cycle_decoder.sv
// ISA I/O slave decoder for a 64-byte window: synchronizes the async strobes,
// assembles byte accesses into 16-bit CAMAC core requests, and holds CHRDY low while waiting on the core.
module sm2201_isa_cycle_decoder #(
  parameter logic [9:0] BASE_ADDR = 10'h100,
  parameter int         TIMEOUT   = 200
) (
  input  logic        isa_clk,
  input  logic        isa_reset,
  input  logic [9:0]  isa_addr,
  input  logic        isa_ale,
  input  logic        isa_aen,
  input  logic        isa_ior,
  input  logic        isa_iow,
  input  logic [7:0]  isa_data_in,
  output logic [7:0]  isa_data_out,
  output logic        isa_data_oe,
  output logic        isa_chrdy,
  output logic [4:0]  core_reg,
  output logic [15:0] core_wdata,
  output logic        core_wr,
  output logic        core_rd,
  input  logic [15:0] core_rdata,
  input  logic        core_ack,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  localparam logic [7:0]  TMAX     = 8'(TIMEOUT - 1);
  localparam logic [10:0] BASE_EXT = {1'b0, BASE_ADDR};

  state_t      state_q, state_d;
  logic        ior_s1_q, ior_s2_q, ior_p_q;
  logic        iow_s1_q, iow_s2_q, iow_p_q;
  logic [9:0]  addr_q;
  logic [7:0]  lo_q, lo_d, hi_q, hi_d, dout_q, dout_d, timer_q, timer_d;
  logic [15:0] wdata_q, wdata_d;
  logic [4:0]  reg_q, reg_d;
  logic        wr_q, wr_d, rd_q, rd_d, is_rd_q, is_rd_d, tmo_q, tmo_d;

  logic        ior_fall, iow_fall, hit, rd_go, wr_go, strobe_rel;
  logic [10:0] addr_ext;

  // Sync flops reset to "asserted" so a strobe held low across reset
  // never looks like a new falling edge afterwards.
  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      ior_s1_q <= 1'b0; ior_s2_q <= 1'b0; ior_p_q <= 1'b0;
      iow_s1_q <= 1'b0; iow_s2_q <= 1'b0; iow_p_q <= 1'b0;
    end else begin
      ior_s1_q <= isa_ior; ior_s2_q <= ior_s1_q; ior_p_q <= ior_s2_q;
      iow_s1_q <= isa_iow; iow_s2_q <= iow_s1_q; iow_p_q <= iow_s2_q;
    end
  end

  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset)   addr_q <= '0;
    else if (isa_ale) addr_q <= isa_addr;
  end

  assign ior_fall   = ior_p_q & ~ior_s2_q;
  assign iow_fall   = iow_p_q & ~iow_s2_q;
  assign addr_ext   = {1'b0, addr_q};
  assign hit        = (addr_ext >= BASE_EXT) && (addr_ext <= BASE_EXT + 11'd63) && !isa_aen;
  // A fall on one strobe while the other is already low is ignored.
  assign rd_go      = ior_fall & iow_s2_q & hit;
  assign wr_go      = iow_fall & ior_s2_q & hit;
  assign strobe_rel = is_rd_q ? ior_s2_q : iow_s2_q;

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dout_d  = dout_q;
    wdata_d = wdata_q;
    reg_d   = reg_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    is_rd_d = is_rd_q;
    tmo_d   = tmo_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (wr_go) begin
          reg_d   = addr_q[5:1];
          is_rd_d = 1'b0;
          if (!addr_q[0]) begin
            lo_d    = isa_data_in;
            state_d = HOLD;
          end else begin
            wdata_d = {isa_data_in, lo_q};
            wr_d    = 1'b1;
            state_d = REQ;
          end
        end else if (rd_go) begin
          reg_d   = addr_q[5:1];
          is_rd_d = 1'b1;
          if (!addr_q[0]) begin
            rd_d    = 1'b1;
            state_d = REQ;
          end else begin
            dout_d  = hi_q;
            state_d = HOLD;
          end
        end
      end
      REQ: begin
        if (core_ack) begin
          wr_d    = 1'b0;
          rd_d    = 1'b0;
          tmo_d   = 1'b0;
          state_d = HOLD;
          if (is_rd_q) begin
            dout_d = core_rdata[7:0];
            hi_d   = core_rdata[15:8];
          end
        end else if (timer_q == TMAX) begin
          wr_d    = 1'b0;
          rd_d    = 1'b0;
          tmo_d   = 1'b1;
          state_d = HOLD;
          if (is_rd_q) begin
            dout_d = 8'hFF;
            hi_d   = 8'hFF;
          end
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      HOLD: begin
        if (strobe_rel) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      dout_q  <= '0;
      wdata_q <= '0;
      reg_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      is_rd_q <= 1'b0;
      tmo_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dout_q  <= dout_d;
      wdata_q <= wdata_d;
      reg_q   <= reg_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      is_rd_q <= is_rd_d;
      tmo_q   <= tmo_d;
      timer_q <= timer_d;
    end
  end

  assign isa_chrdy    = (state_q != REQ);
  assign isa_data_oe  = (state_q == HOLD) && is_rd_q && !ior_s2_q;
  assign isa_data_out = dout_q;
  assign core_reg     = reg_q;
  assign core_wdata   = wdata_q;
  assign core_wr      = wr_q;
  assign core_rd      = rd_q;
  assign timeout_err  = tmo_q;

endmodule

// File: tb/tb_sm2201_isa_cycle_decoder.sv
// Directed bench for the ISA cycle decoder: byte assembly, read split,
// timeout, address misses, strobe conflicts and asynchronous reset.
module tb_sm2201_isa_cycle_decoder;

  logic        isa_clk = 1'b0;
  logic        isa_reset;
  logic [9:0]  isa_addr;
  logic        isa_ale, isa_aen, isa_ior, isa_iow;
  logic [7:0]  isa_data_in, isa_data_out;
  logic        isa_data_oe, isa_chrdy;
  logic [4:0]  core_reg;
  logic [15:0] core_wdata, core_rdata;
  logic        core_wr, core_rd, core_ack, timeout_err;

  int checks   = 0;
  int failures = 0;

  sm2201_isa_cycle_decoder dut (
    .isa_clk(isa_clk), .isa_reset(isa_reset), .isa_addr(isa_addr),
    .isa_ale(isa_ale), .isa_aen(isa_aen), .isa_ior(isa_ior), .isa_iow(isa_iow),
    .isa_data_in(isa_data_in), .isa_data_out(isa_data_out),
    .isa_data_oe(isa_data_oe), .isa_chrdy(isa_chrdy), .core_reg(core_reg),
    .core_wdata(core_wdata), .core_wr(core_wr), .core_rd(core_rd),
    .core_rdata(core_rdata), .core_ack(core_ack), .timeout_err(timeout_err)
  );

  always #5 isa_clk = ~isa_clk;

  task automatic tick(input int n);
    repeat (n) @(posedge isa_clk);
    #1;
  endtask

  task automatic latch_addr(input logic [9:0] a);
    isa_addr = a;
    isa_ale  = 1'b1;
    tick(1);
    isa_ale  = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (isa_chrdy !== 1'b1) begin failures++; $display("FAIL rst_chrdy got=%b exp=1", isa_chrdy); end
    checks++; if (isa_data_oe !== 1'b0) begin failures++; $display("FAIL rst_oe got=%b exp=0", isa_data_oe); end
    checks++; if ({core_wr, core_rd} !== 2'b00) begin failures++; $display("FAIL rst_req got=%b exp=00", {core_wr, core_rd}); end
    checks++; if (isa_data_out !== 8'h00) begin failures++; $display("FAIL rst_dout got=%h exp=00", isa_data_out); end
    checks++; if (core_wdata !== 16'h0000) begin failures++; $display("FAIL rst_wdata got=%h exp=0000", core_wdata); end
    checks++; if (core_reg !== 5'd0) begin failures++; $display("FAIL rst_reg got=%0d exp=0", core_reg); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL rst_tmo got=%b exp=0", timeout_err); end
    tick(2);
    isa_reset = 1'b1;
    tick(3);
  endtask

  task automatic test_write;
    latch_addr(10'h100);
    isa_data_in = 8'h08;
    isa_iow = 1'b0;
    tick(3);
    checks++; if (isa_chrdy !== 1'b1) begin failures++; $display("FAIL wr_lo_chrdy got=%b exp=1", isa_chrdy); end
    checks++; if (core_wr !== 1'b0) begin failures++; $display("FAIL wr_lo_nocore got=%b exp=0", core_wr); end
    isa_iow = 1'b1;
    tick(3);
    latch_addr(10'h101);
    isa_data_in = 8'h42;
    isa_iow = 1'b0;
    tick(3);
    checks++; if (core_wr !== 1'b1) begin failures++; $display("FAIL wr_hi_req got=%b exp=1", core_wr); end
    checks++; if (core_wdata !== 16'h4208) begin failures++; $display("FAIL wr_hi_wdata got=%h exp=4208", core_wdata); end
    checks++; if (core_reg !== 5'd0) begin failures++; $display("FAIL wr_hi_reg got=%0d exp=0", core_reg); end
    checks++; if (isa_chrdy !== 1'b0) begin failures++; $display("FAIL wr_hi_chrdy got=%b exp=0", isa_chrdy); end
    tick(3);
    checks++; if ({isa_chrdy, core_wr} !== 2'b01) begin failures++; $display("FAIL wr_wait got=%b exp=01", {isa_chrdy, core_wr}); end
    core_ack = 1'b1;
    tick(1);
    core_ack = 1'b0;
    checks++; if (core_wr !== 1'b0) begin failures++; $display("FAIL wr_drop got=%b exp=0", core_wr); end
    checks++; if (isa_chrdy !== 1'b1) begin failures++; $display("FAIL wr_done_chrdy got=%b exp=1", isa_chrdy); end
    checks++; if (isa_data_oe !== 1'b0) begin failures++; $display("FAIL wr_oe got=%b exp=0", isa_data_oe); end
    isa_iow = 1'b1;
    tick(3);
  endtask

  task automatic test_read;
    latch_addr(10'h13E);
    core_rdata = 16'h4208;
    isa_ior = 1'b0;
    tick(3);
    checks++; if (core_rd !== 1'b1) begin failures++; $display("FAIL rd_req got=%b exp=1", core_rd); end
    checks++; if (core_reg !== 5'd31) begin failures++; $display("FAIL rd_reg got=%0d exp=31", core_reg); end
    checks++; if (isa_chrdy !== 1'b0) begin failures++; $display("FAIL rd_chrdy got=%b exp=0", isa_chrdy); end
    core_ack = 1'b1;
    tick(1);
    core_ack = 1'b0;
    core_rdata = 16'h0000;
    checks++; if (isa_data_out !== 8'h08) begin failures++; $display("FAIL rd_lo_data got=%h exp=08", isa_data_out); end
    checks++; if (isa_data_oe !== 1'b1) begin failures++; $display("FAIL rd_lo_oe got=%b exp=1", isa_data_oe); end
    checks++; if (core_rd !== 1'b0) begin failures++; $display("FAIL rd_drop got=%b exp=0", core_rd); end
    isa_ior = 1'b1;
    tick(2);
    checks++; if (isa_data_oe !== 1'b0) begin failures++; $display("FAIL rd_release_oe got=%b exp=0", isa_data_oe); end
    tick(1);
    latch_addr(10'h13F);
    isa_ior = 1'b0;
    tick(3);
    checks++; if (core_rd !== 1'b0) begin failures++; $display("FAIL rd_hi_nocore got=%b exp=0", core_rd); end
    checks++; if (isa_data_out !== 8'h42) begin failures++; $display("FAIL rd_hi_data got=%h exp=42", isa_data_out); end
    checks++; if ({isa_data_oe, isa_chrdy} !== 2'b11) begin failures++; $display("FAIL rd_hi_oe_chrdy got=%b exp=11", {isa_data_oe, isa_chrdy}); end
    isa_ior = 1'b1;
    tick(3);
  endtask

  task automatic test_ack_idle;
    core_rdata = 16'hFFFF;
    core_ack = 1'b1;
    tick(2);
    core_ack = 1'b0;
    core_rdata = 16'h0000;
    tick(1);
    checks++; if (isa_data_out !== 8'h42) begin failures++; $display("FAIL ack_idle_data got=%h exp=42", isa_data_out); end
    checks++; if (isa_chrdy !== 1'b1) begin failures++; $display("FAIL ack_idle_chrdy got=%b exp=1", isa_chrdy); end
  endtask

  task automatic test_miss;
    latch_addr(10'h0F0);
    isa_ior = 1'b0;
    tick(4);
    checks++; if ({core_rd, isa_chrdy, isa_data_oe} !== 3'b010) begin failures++; $display("FAIL miss_low got=%b exp=010", {core_rd, isa_chrdy, isa_data_oe}); end
    checks++; if (isa_data_out !== 8'h42) begin failures++; $display("FAIL miss_low_data got=%h exp=42", isa_data_out); end
    isa_ior = 1'b1;
    tick(3);
    latch_addr(10'h140);
    isa_ior = 1'b0;
    tick(4);
    checks++; if ({core_rd, isa_chrdy} !== 2'b01) begin failures++; $display("FAIL miss_high got=%b exp=01", {core_rd, isa_chrdy}); end
    isa_ior = 1'b1;
    tick(3);
    latch_addr(10'h101);
    isa_aen = 1'b1;
    isa_data_in = 8'h77;
    isa_iow = 1'b0;
    tick(4);
    checks++; if ({core_wr, isa_chrdy, isa_data_oe} !== 3'b010) begin failures++; $display("FAIL miss_aen got=%b exp=010", {core_wr, isa_chrdy, isa_data_oe}); end
    isa_iow = 1'b1;
    tick(3);
    isa_aen = 1'b0;
  endtask

  task automatic test_both_low;
    latch_addr(10'h100);
    isa_ior = 1'b0;
    isa_iow = 1'b0;
    tick(4);
    checks++; if ({core_rd, core_wr, isa_chrdy} !== 3'b001) begin failures++; $display("FAIL both_low got=%b exp=001", {core_rd, core_wr, isa_chrdy}); end
    isa_ior = 1'b1;
    isa_iow = 1'b1;
    tick(3);
  endtask

  task automatic test_timeout;
    int n;
    latch_addr(10'h100);
    isa_ior = 1'b0;
    tick(3);
    checks++; if (isa_chrdy !== 1'b0) begin failures++; $display("FAIL tmo_start got=%b exp=0", isa_chrdy); end
    n = 0;
    while (isa_chrdy === 1'b0 && n < 300) begin
      tick(1);
      n++;
    end
    checks++; if (n !== 200) begin failures++; $display("FAIL tmo_cycles got=%0d exp=200", n); end
    checks++; if (isa_data_out !== 8'hFF) begin failures++; $display("FAIL tmo_data got=%h exp=ff", isa_data_out); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_err got=%b exp=1", timeout_err); end
    checks++; if ({core_rd, isa_data_oe} !== 2'b01) begin failures++; $display("FAIL tmo_rd_oe got=%b exp=01", {core_rd, isa_data_oe}); end
    isa_ior = 1'b1;
    tick(3);
    latch_addr(10'h101);
    isa_ior = 1'b0;
    tick(3);
    checks++; if (isa_data_out !== 8'hFF) begin failures++; $display("FAIL tmo_hi_latch got=%h exp=ff", isa_data_out); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_sticky got=%b exp=1", timeout_err); end
    isa_ior = 1'b1;
    tick(3);
    isa_data_in = 8'h55;
    isa_iow = 1'b0;
    tick(3);
    checks++; if (core_wdata !== 16'h5508) begin failures++; $display("FAIL tmo_wr_wdata got=%h exp=5508", core_wdata); end
    core_ack = 1'b1;
    tick(1);
    core_ack = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL tmo_clear got=%b exp=0", timeout_err); end
    isa_iow = 1'b1;
    tick(3);
  endtask

  task automatic test_reset_mid_req;
    latch_addr(10'h13E);
    isa_ior = 1'b0;
    tick(3);
    checks++; if ({core_rd, core_reg} !== {1'b1, 5'd31}) begin failures++; $display("FAIL rmr_pre got=%b/%0d exp=1/31", core_rd, core_reg); end
    tick(5);
    isa_reset = 1'b0;
    #1;
    checks++; if ({isa_chrdy, core_rd, timeout_err} !== 3'b100) begin failures++; $display("FAIL rmr_async got=%b exp=100", {isa_chrdy, core_rd, timeout_err}); end
    checks++; if (isa_data_out !== 8'h00 || core_reg !== 5'd0 || core_wdata !== 16'h0) begin failures++; $display("FAIL rmr_clear got=%h/%0d/%h exp=00/0/0000", isa_data_out, core_reg, core_wdata); end
    tick(2);
    isa_reset = 1'b1;
    tick(6);
    checks++; if ({core_rd, isa_chrdy} !== 2'b01) begin failures++; $display("FAIL rmr_no_restart got=%b exp=01", {core_rd, isa_chrdy}); end
    isa_ior = 1'b1;
    tick(3);
    latch_addr(10'h100);
    core_rdata = 16'hBEEF;
    isa_ior = 1'b0;
    tick(3);
    checks++; if (core_rd !== 1'b1) begin failures++; $display("FAIL rmr_fresh_req got=%b exp=1", core_rd); end
    core_ack = 1'b1;
    tick(1);
    core_ack = 1'b0;
    checks++; if (isa_data_out !== 8'hEF) begin failures++; $display("FAIL rmr_fresh_data got=%h exp=ef", isa_data_out); end
    isa_ior = 1'b1;
    tick(3);
  endtask

  initial begin
    isa_reset   = 1'b0;
    isa_addr    = '0;
    isa_ale     = 1'b0;
    isa_aen     = 1'b0;
    isa_ior     = 1'b1;
    isa_iow     = 1'b1;
    isa_data_in = '0;
    core_rdata  = '0;
    core_ack    = 1'b0;
    test_reset;
    test_write;
    test_read;
    test_ack_idle;
    test_miss;
    test_both_low;
    test_timeout;
    test_reset_mid_req;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
